// File: rtl/uart_tx_sched.sv
// uart_tx_sched: round-robin arbiter for NUM_REQ byte sources sharing one
// 8N1 UART transmit line. A grant is issued only from IDLE. The granted byte
// is latched, and its frame starts on the same edge that pulses REQ_READY.
module uart_tx_sched #(
  parameter int BAUD_RATE     = 9600,
  parameter int CLOCK_FREQ_HZ = 12000000,
  parameter int NUM_REQ       = 4
) (
  input  logic                                            CLK,
  input  logic                                            RESETN,
  input  logic [NUM_REQ-1:0]                              REQ_VALID,
  input  logic [8*NUM_REQ-1:0]                            REQ_DATA,
  output logic [NUM_REQ-1:0]                              REQ_READY,
  output logic                                            TX,
  output logic                                            BUSY,
  output logic [((NUM_REQ > 2) ? $clog2(NUM_REQ) : 1)-1:0] GRANT_ID
);

  localparam int BIT_PERIOD = CLOCK_FREQ_HZ / BAUD_RATE;
  localparam int CW         = (BIT_PERIOD > 2) ? $clog2(BIT_PERIOD) : 1;
  localparam int IDW        = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(BIT_PERIOD - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t          state_reg;
  logic [CW-1:0]   bit_cnt_reg;
  logic [2:0]      data_idx_reg;
  logic [7:0]      shift_reg;
  logic [IDW-1:0]  last_reg;

  logic [7:0]      req_byte [NUM_REQ];
  logic            grant_found;
  logic [IDW-1:0]  grant_idx;
  logic [IDW-1:0]  cand_sel;
  int              cand_idx;

  // Unpack the flat data bus into one byte per requester.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_byte[gi] = REQ_DATA[8*gi +: 8];
  end

  wire bit_done = (bit_cnt_reg == BIT_LAST);

  // Round-robin search starting just after the last granted requester, so the
  // most recently served source always has the lowest priority.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_idx    = 0;
    cand_sel    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand_idx = int'(last_reg) + i;
      if (cand_idx >= NUM_REQ) cand_idx = cand_idx - NUM_REQ;
      cand_sel = IDW'(cand_idx);
      if (!grant_found && REQ_VALID[cand_sel]) begin
        grant_found = 1'b1;
        grant_idx   = cand_sel;
      end
    end
  end

  // Frame FSM: all outputs are registered so TX and REQ_READY change together.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_reg    <= S_IDLE;
      TX           <= 1'b1;
      BUSY         <= 1'b0;
      REQ_READY    <= '0;
      GRANT_ID     <= '0;
      last_reg     <= IDW'(NUM_REQ - 1);
      bit_cnt_reg  <= '0;
      data_idx_reg <= '0;
      shift_reg    <= '0;
    end else begin
      REQ_READY <= '0;
      case (state_reg)
        S_IDLE: begin
          TX           <= 1'b1;
          BUSY         <= 1'b0;
          bit_cnt_reg  <= '0;
          data_idx_reg <= '0;
          if (grant_found) begin
            REQ_READY <= NUM_REQ'(1) << grant_idx;
            shift_reg <= req_byte[grant_idx];
            GRANT_ID  <= grant_idx;
            last_reg  <= grant_idx;
            state_reg <= S_START;
            TX        <= 1'b0;
            BUSY      <= 1'b1;
          end
        end
        S_START: begin
          if (bit_done) begin
            bit_cnt_reg <= '0;
            state_reg   <= S_DATA;
            TX          <= shift_reg[0];
            shift_reg   <= shift_reg >> 1;
          end else begin
            bit_cnt_reg <= bit_cnt_reg + CW'(1);
          end
        end
        S_DATA: begin
          if (bit_done) begin
            bit_cnt_reg <= '0;
            if (data_idx_reg == 3'd7) begin
              state_reg <= S_STOP;
              TX        <= 1'b1;
            end else begin
              data_idx_reg <= data_idx_reg + 3'd1;
              TX           <= shift_reg[0];
              shift_reg    <= shift_reg >> 1;
            end
          end else begin
            bit_cnt_reg <= bit_cnt_reg + CW'(1);
          end
        end
        S_STOP: begin
          if (bit_done) begin
            bit_cnt_reg <= '0;
            state_reg   <= S_IDLE;
            BUSY        <= 1'b0;
          end else begin
            bit_cnt_reg <= bit_cnt_reg + CW'(1);
          end
        end
        default: begin
          state_reg <= S_IDLE;
          TX        <= 1'b1;
          BUSY      <= 1'b0;
        end
      endcase
    end
  end

endmodule
